// File: rtl/cpu_datapath_pkg.sv
// Shared constants for the single-bus CPU datapath: width, bus source indices
// and ALU operation one-hot bit positions.
package cpu_datapath_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int C_FIELD_W  = 19;

  typedef logic [DATA_WIDTH-1:0] word_t;

  // Bus source indices; a lower index wins when several strobes are high.
  localparam int NUM_SRC = 27;
  localparam int SRC_HI  = 16;
  localparam int SRC_LO  = 17;
  localparam int SRC_ZHI = 18;
  localparam int SRC_ZLO = 19;
  localparam int SRC_PC  = 20;
  localparam int SRC_IR  = 21;
  localparam int SRC_MDR = 22;
  localparam int SRC_IN  = 23;
  localparam int SRC_C   = 24;
  localparam int SRC_Y   = 25;
  localparam int SRC_MAR = 26;

  // ALU op bit positions; a lower bit wins when several ops are high.
  localparam int NUM_OPS = 13;
  localparam int OP_AND  = 0;
  localparam int OP_OR   = 1;
  localparam int OP_ADD  = 2;
  localparam int OP_SUB  = 3;
  localparam int OP_MUL  = 4;
  localparam int OP_DIV  = 5;
  localparam int OP_SHR  = 6;
  localparam int OP_SHRA = 7;
  localparam int OP_SHL  = 8;
  localparam int OP_ROR  = 9;
  localparam int OP_ROL  = 10;
  localparam int OP_NEG  = 11;
  localparam int OP_NOT  = 12;

  function automatic word_t sext_c(input word_t ir);
    return {{(DATA_WIDTH-C_FIELD_W){ir[C_FIELD_W-1]}}, ir[C_FIELD_W-1:0]};
  endfunction

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: operand A is Y, operand B is the bus; produces the
// 64-bit value that Z loads.
module datapath_alu
  import cpu_datapath_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [NUM_OPS-1:0] op,
  output logic [2*WIDTH-1:0] result
);

  localparam int SH_W = $clog2(WIDTH);

  logic [SH_W-1:0]          sh_s;
  logic [WIDTH-1:0]         zero_s;
  logic signed [2*WIDTH-1:0] prod_s;
  logic signed [WIDTH-1:0]  quo_s;
  logic signed [WIDTH-1:0]  rem_s;
  logic [2*WIDTH-1:0]       ror_s;
  logic [2*WIDTH-1:0]       rol_s;

  assign sh_s   = b[SH_W-1:0];
  assign zero_s = {WIDTH{1'b0}};
  assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
  // Rotates shift a doubled copy so the wrapped bits fall into place.
  assign ror_s  = {a, a} >> sh_s;
  assign rol_s  = {a, a} << sh_s;

  // Signed divide, guarded so a zero divisor never reaches the operator.
  always_comb begin
    quo_s = {WIDTH{1'b0}};
    rem_s = {WIDTH{1'b0}};
    if (b != zero_s) begin
      quo_s = $signed(a) / $signed(b);
      rem_s = $signed(a) % $signed(b);
    end else begin
      quo_s = {WIDTH{1'b0}};
      rem_s = {WIDTH{1'b0}};
    end
  end

  // Priority op select.
  always_comb begin
    result = {(2*WIDTH){1'b0}};
    if      (op[OP_AND])  result = {zero_s, a & b};
    else if (op[OP_OR])   result = {zero_s, a | b};
    else if (op[OP_ADD])  result = {zero_s, a + b};
    else if (op[OP_SUB])  result = {zero_s, a - b};
    else if (op[OP_MUL])  result = prod_s;
    else if (op[OP_DIV])  result = {rem_s, quo_s};
    else if (op[OP_SHR])  result = {zero_s, a >> sh_s};
    else if (op[OP_SHRA]) result = {zero_s, $signed(a) >>> sh_s};
    else if (op[OP_SHL])  result = {zero_s, a << sh_s};
    else if (op[OP_ROR])  result = {zero_s, ror_s[WIDTH-1:0]};
    else if (op[OP_ROL])  result = {zero_s, rol_s[2*WIDTH-1:WIDTH]};
    else if (op[OP_NEG])  result = {zero_s, zero_s - b};
    else if (op[OP_NOT])  result = {zero_s, ~b};
    else                  result = {(2*WIDTH){1'b0}};
  end

endmodule

// File: rtl/cpu_datapath.sv
// Single-bus CPU datapath: one-hot strobes pick the bus driver and the
// registers that load from it; Z captures the ALU result.
module cpu_datapath
  import cpu_datapath_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
  input  logic             R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic             HIout, LOout, Zhighout, Zlowout, PCout, IRout, MDRout,
  input  logic             INout, Cout, Yout, MARout,
  input  logic             Read,
  input  logic             IncPC,
  input  logic             AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT,
  input  logic             R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
  input  logic             R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic             HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin,
  input  logic [WIDTH-1:0] IN,
  output logic [WIDTH-1:0] BusMuxOut,
  output logic [WIDTH-1:0] PC
);

  logic [WIDTH-1:0]   regs_r [16];
  logic [WIDTH-1:0]   hi_r, lo_r, y_r, pc_r, ir_r, mar_r, mdr_r;
  logic [2*WIDTH-1:0] z_r;

  logic [NUM_SRC-1:0] sel_s;
  logic [WIDTH-1:0]   src_s [NUM_SRC];
  logic [WIDTH-1:0]   bus_s;
  logic [15:0]        rin_s;
  logic [NUM_OPS-1:0] op_s;
  logic [2*WIDTH-1:0] alu_s;

  assign sel_s = {MARout, Yout, Cout, INout, MDRout, IRout, PCout, Zlowout, Zhighout,
                  LOout, HIout, R15out, R14out, R13out, R12out, R11out, R10out, R9out,
                  R8out, R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
  assign rin_s = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
  assign op_s  = {NOT, NEG, ROL, ROR, SHL, SHRA, SHR, DIV, MUL, SUB, ADD, OR, AND};

  for (genvar g = 0; g < 16; g++) begin : g_rsrc
    assign src_s[g] = regs_r[g];
  end
  assign src_s[SRC_HI]  = hi_r;
  assign src_s[SRC_LO]  = lo_r;
  assign src_s[SRC_ZHI] = z_r[2*WIDTH-1:WIDTH];
  assign src_s[SRC_ZLO] = z_r[WIDTH-1:0];
  assign src_s[SRC_PC]  = pc_r;
  assign src_s[SRC_IR]  = ir_r;
  assign src_s[SRC_MDR] = mdr_r;
  assign src_s[SRC_IN]  = IN;
  assign src_s[SRC_C]   = {{(WIDTH-C_FIELD_W){ir_r[C_FIELD_W-1]}}, ir_r[C_FIELD_W-1:0]};
  assign src_s[SRC_Y]   = y_r;
  assign src_s[SRC_MAR] = mar_r;

  // Bus mux: scan from lowest priority up so the lowest asserted index wins.
  always_comb begin
    bus_s = {WIDTH{1'b0}};
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      bus_s = sel_s[i] ? src_s[i] : bus_s;
    end
  end

  assign BusMuxOut = bus_s;
  assign PC        = pc_r;

  datapath_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (y_r),
    .b      (bus_s),
    .op     (op_s),
    .result (alu_s)
  );

  // Register file and special registers; reset beats every load strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) regs_r[i] <= {WIDTH{1'b0}};
      hi_r  <= {WIDTH{1'b0}};
      lo_r  <= {WIDTH{1'b0}};
      y_r   <= {WIDTH{1'b0}};
      pc_r  <= {WIDTH{1'b0}};
      ir_r  <= {WIDTH{1'b0}};
      mar_r <= {WIDTH{1'b0}};
      mdr_r <= {WIDTH{1'b0}};
      z_r   <= {(2*WIDTH){1'b0}};
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (rin_s[i]) regs_r[i] <= bus_s;
      end
      if (HIin)  hi_r  <= bus_s;
      if (LOin)  lo_r  <= bus_s;
      if (Yin)   y_r   <= bus_s;
      if (IRin)  ir_r  <= bus_s;
      if (MARin) mar_r <= bus_s;
      if (MDRin) mdr_r <= Read ? IN : bus_s;
      if (Zin)   z_r   <= alu_s;
      if (IncPC)     pc_r <= pc_r + {{(WIDTH-1){1'b0}}, 1'b1};
      else if (PCin) pc_r <= bus_s;
    end
  end

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed sequences plus a table of
// ALU vectors, with bus expectations queued and popped at the sampling edge.
module tb_cpu_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] rout, rin;
  logic        hi_out, lo_out, zh_out, zl_out, pc_out, ir_out, mdr_out, in_out, c_out, y_out, mar_out;
  logic        rd, inc_pc;
  logic [12:0] ops;
  logic        hi_in, lo_in, pc_in, ir_in, z_in, y_in, mar_in, mdr_in;
  logic [31:0] in_data;
  logic [31:0] bus, pc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_entry_t;
  sb_entry_t sb_q[$];

  typedef struct {
    string       name;
    logic [12:0] op;
    logic [31:0] a, b, lo, hi;
  } alu_vec_t;
  alu_vec_t vecs[16];

  always #5 clk = ~clk;

  cpu_datapath dut (
    .clk(clk), .reset(reset),
    .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
    .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
    .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .HIout(hi_out), .LOout(lo_out), .Zhighout(zh_out), .Zlowout(zl_out),
    .PCout(pc_out), .IRout(ir_out), .MDRout(mdr_out), .INout(in_out),
    .Cout(c_out), .Yout(y_out), .MARout(mar_out),
    .Read(rd), .IncPC(inc_pc),
    .AND(ops[0]), .OR(ops[1]), .ADD(ops[2]), .SUB(ops[3]), .MUL(ops[4]),
    .DIV(ops[5]), .SHR(ops[6]), .SHRA(ops[7]), .SHL(ops[8]), .ROR(ops[9]),
    .ROL(ops[10]), .NEG(ops[11]), .NOT(ops[12]),
    .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
    .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
    .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .HIin(hi_in), .LOin(lo_in), .PCin(pc_in), .IRin(ir_in), .Zin(z_in),
    .Yin(y_in), .MARin(mar_in), .MDRin(mdr_in),
    .IN(in_data), .BusMuxOut(bus), .PC(pc)
  );

  task automatic clr();
    reset = 1'b0; rout = 16'h0; rin = 16'h0; ops = 13'h0;
    {hi_out, lo_out, zh_out, zl_out, pc_out, ir_out, mdr_out, in_out, c_out, y_out, mar_out} = 11'h0;
    {hi_in, lo_in, pc_in, ir_in, z_in, y_in, mar_in, mdr_in} = 8'h0;
    rd = 1'b0; inc_pc = 1'b0; in_data = 32'h0;
  endtask

  // Hold current strobes across one rising edge, then release them.
  task automatic cycle();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic set_src(input int idx);
    if (idx < 16) rout[idx] = 1'b1;
    else begin
      case (idx)
        16: hi_out = 1'b1;
        17: lo_out = 1'b1;
        18: zh_out = 1'b1;
        19: zl_out = 1'b1;
        20: pc_out = 1'b1;
        21: ir_out = 1'b1;
        22: mdr_out = 1'b1;
        23: in_out = 1'b1;
        24: c_out = 1'b1;
        25: y_out = 1'b1;
        26: mar_out = 1'b1;
        default: ;
      endcase
    end
  endtask

  // Queue the expected bus value, then compare on the falling edge.
  task automatic chk_bus(input string name, input logic [31:0] exp);
    sb_entry_t e;
    sb_q.push_back('{name, exp});
    @(negedge clk);
    e = sb_q.pop_front();
    checks++;
    if (bus !== e.exp) begin
      errors++;
      $display("FAIL %s: BusMuxOut=%h expected %h", e.name, bus, e.exp);
    end
  endtask

  task automatic chk_pc(input string name, input logic [31:0] exp);
    @(negedge clk);
    checks++;
    if (pc !== exp) begin
      errors++;
      $display("FAIL %s: PC=%h expected %h", name, pc, exp);
    end
  endtask

  initial begin
    vecs[0]  = '{"add",      13'h0004, 32'd7,        32'hFFFFFFFE, 32'd5,        32'h0};
    vecs[1]  = '{"sub",      13'h0008, 32'd7,        32'hFFFFFFFE, 32'd9,        32'h0};
    vecs[2]  = '{"mul",      13'h0010, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, 32'hFFFFFFFF};
    vecs[3]  = '{"div",      13'h0020, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
    vecs[4]  = '{"div0",     13'h0020, 32'd100,      32'd0,        32'h0,        32'h0};
    vecs[5]  = '{"shra",     13'h0080, 32'h80000000, 32'd4,        32'hF8000000, 32'h0};
    vecs[6]  = '{"shr",      13'h0040, 32'h80000000, 32'd4,        32'h08000000, 32'h0};
    vecs[7]  = '{"shl",      13'h0100, 32'h00000001, 32'd31,       32'h80000000, 32'h0};
    vecs[8]  = '{"rol",      13'h0400, 32'h80000001, 32'd1,        32'h00000003, 32'h0};
    vecs[9]  = '{"ror",      13'h0200, 32'h80000001, 32'd1,        32'hC0000000, 32'h0};
    vecs[10] = '{"and",      13'h0001, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 32'h0};
    vecs[11] = '{"or",       13'h0002, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 32'h0};
    vecs[12] = '{"neg",      13'h0800, 32'd3,        32'd5,        32'hFFFFFFFB, 32'h0};
    vecs[13] = '{"not",      13'h1000, 32'd3,        32'd0,        32'hFFFFFFFF, 32'h0};
    vecs[14] = '{"noop",     13'h0000, 32'd3,        32'd5,        32'h0,        32'h0};
    vecs[15] = '{"and_prio", 13'h0005, 32'h0000000C, 32'h0000000A, 32'h00000008, 32'h0};

    clr();
    // Reset with every load and increment strobe active.
    reset = 1'b1; rin = 16'hFFFF; rd = 1'b1; inc_pc = 1'b1; in_data = 32'hDEADBEEF;
    {hi_in, lo_in, pc_in, ir_in, z_in, y_in, mar_in, mdr_in} = 8'hFF;
    cycle();
    chk_bus("reset_idle_bus", 32'h0);
    chk_pc("reset_pc", 32'h0);
    for (int s = 0; s < 27; s++) begin
      if (s != 23) begin
        set_src(s);
        chk_bus($sformatf("reset_src%0d", s), 32'h0);
        cycle();
      end
    end

    // MDR from memory, then MDR -> R0.
    rd = 1'b1; mdr_in = 1'b1; in_data = 32'h22; cycle();
    mdr_out = 1'b1; rin[0] = 1'b1; chk_bus("mdrout", 32'h22); cycle();
    rout[0] = 1'b1; chk_bus("r0", 32'h22); cycle();

    // NOT sequence into R5.
    rout[3] = 1'b1; y_in = 1'b1; cycle();
    rout[0] = 1'b1; ops[12] = 1'b1; z_in = 1'b1; cycle();
    zl_out = 1'b1; rin[5] = 1'b1; cycle();
    rout[5] = 1'b1; chk_bus("not_r5", 32'hFFFFFFDD); cycle();

    // Fetch: IncPC beats PCin.
    pc_out = 1'b1; inc_pc = 1'b1; mar_in = 1'b1; pc_in = 1'b1; mdr_in = 1'b1; rd = 1'b1;
    in_data = 32'h92800000; cycle();
    chk_pc("fetch_pc", 32'd1);
    mar_out = 1'b1; chk_bus("fetch_mar", 32'h0); cycle();
    mdr_out = 1'b1; ir_in = 1'b1; chk_bus("fetch_mdr", 32'h92800000); cycle();
    ir_out = 1'b1; chk_bus("fetch_ir", 32'h92800000); cycle();
    c_out = 1'b1; chk_bus("c_zero", 32'h0); cycle();
    in_out = 1'b1; in_data = 32'h00040005; ir_in = 1'b1; cycle();
    c_out = 1'b1; chk_bus("c_sext", 32'hFFFC0005); cycle();

    // PC load, increment and wrap.
    in_out = 1'b1; in_data = 32'h100; pc_in = 1'b1; cycle();
    chk_pc("pc_load", 32'h100);
    inc_pc = 1'b1; cycle();
    chk_pc("pc_inc", 32'h101);
    in_out = 1'b1; in_data = 32'hFFFFFFFF; pc_in = 1'b1; cycle();
    inc_pc = 1'b1; cycle();
    chk_pc("pc_wrap", 32'h0);

    // Bus priority.
    rout[0] = 1'b1; mdr_out = 1'b1; chk_bus("prio_r0_mdr", 32'h22); cycle();
    in_out = 1'b1; in_data = 32'h55; hi_in = 1'b1; cycle();
    hi_out = 1'b1; in_out = 1'b1; in_data = 32'h66; chk_bus("prio_hi_in", 32'h55); cycle();
    rout[5] = 1'b1; rout[9] = 1'b1; chk_bus("prio_r5_r9", 32'hFFFFFFDD); cycle();

    // ALU vector table: Y load, op into Z, then each half of Z on the bus.
    for (int v = 0; v < 16; v++) begin
      in_out = 1'b1; in_data = vecs[v].a; y_in = 1'b1; cycle();
      in_out = 1'b1; in_data = vecs[v].b; ops = vecs[v].op; z_in = 1'b1; cycle();
      zl_out = 1'b1; chk_bus({vecs[v].name, "_lo"}, vecs[v].lo); cycle();
      zh_out = 1'b1; chk_bus({vecs[v].name, "_hi"}, vecs[v].hi); cycle();
    end

    // Reset overrides increment and loads mid-run.
    reset = 1'b1; inc_pc = 1'b1; rin[5] = 1'b1; in_out = 1'b1; in_data = 32'h77; cycle();
    chk_pc("reset2_pc", 32'h0);
    rout[5] = 1'b1; chk_bus("reset2_r5", 32'h0); cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- 32-bit single-bus CPU datapath: 16 general registers R0–R15, plus PC, IR, HI, LO, Y, Z (64-bit), MAR and MDR.
- All sources share one 32-bit bus (BusMuxOut). The bus driver and register loads come from external one-hot control strobes issued by a control unit or bench.
- An ALU combines Y (operand A) with the bus (operand B) into Z.
- Sits between control unit and memory; IN acts as memory read data.

Parameters:
- WIDTH, 32, data/bus width. All registers WIDTH; Z is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; clears all registers.
- R0out..R15out  input  1 each  drive R<n> onto bus.
- HIout, LOout, Zhighout, Zlowout, PCout, IRout, MDRout, INout, Cout, Yout, MARout  input  1 each  bus source selects.
- Read  input  1  MDR source select: 1 = IN (memory data), 0 = bus.
- IncPC  input  1  PC increment enable.
- AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT  input  1 each  ALU operation select.
- R0in..R15in, HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin  input  1 each  register load enables.
- IN  input  32  memory read data / input port.
- BusMuxOut  output  32  current bus value (combinational).
- PC  output  32  program counter register.

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset: at a rising edge with reset=1, all registers clear to 0, including PC, IR, HI, LO, Y, Z, MAR, MDR and R0–R15. Reset overrides every load and increment strobe.
- Bus mux (combinational): drives the value of the single asserted *out strobe.
  - Cout drives the sign-extended IR[18:0].
  - INout drives IN.
  - Zhighout drives Z[63:32]; Zlowout drives Z[31:0].
  - Priority when several strobes are asserted, highest first: R0..R15, HI, LO, Zhigh, Zlow, PC, IR, MDR, IN, C, Y, MAR.
  - No strobe asserted: bus = 0.
- Register loads: at a rising edge, each register whose *in is high loads BusMuxOut.
  - MDR exception: loads IN when Read=1, otherwise BusMuxOut.
  - R0 is an ordinary register.
- PC:
  - IncPC=1 → PC <= PC+1, wrapping at 2^32; IncPC takes priority over PCin.
  - PCin alone → PC <= bus.
- ALU (combinational): A = Y, B = BusMuxOut. One op selected; priority order is the port list order. No op → result 0.
  - AND, OR, ADD, SUB (A−B): 32-bit result, upper half 0, no carry kept.
  - MUL: signed 64-bit A*B.
  - DIV: signed; low = quotient, high = remainder. B=0 → Z = 0.
  - SHR, SHRA, SHL, ROR, ROL: operate on A by B[4:0]; SHRA is arithmetic.
  - NEG = −B; NOT = ~B; upper half 0.
- Zin → Z <= ALU result (64 bits).
- Latency: strobes applied after edge k take effect at edge k+1. A typical operation is 3 cycles (Y load, op/Z load, Zlow→dest).

Decomposition:
- Shared package: WIDTH constant, bus-source index constants, ALU op one-hot bit positions.
- One sub-module, datapath_alu: Y, bus and op strobes in → 64-bit result out.
- Registers are inline always blocks.

Test Plan:
- Reset with all *in strobes=1 and nonzero IN → all registers 0, BusMuxOut=0, PC=0.
- Read=1, MDRin, IN=0x22; next cycle MDRout+R0in → R0=0x22, BusMuxOut=0x22 while MDRout is high.
- NOT sequence: R0=0x22, R3→Y; R0out+NOT+Zin; Zlowout+R5in → R5=0xFFFFFFDD.
- Fetch: IncPC+MARin+PCin+MDRin+Read, IN=0x92800000 → PC=1, MDR=0x92800000, MAR=0. Then MDRout+IRin → IR=0x92800000.
- ADD/SUB/MUL: Y=7, bus=0xFFFFFFFE (−2) → ADD Z=5, SUB Z=9, MUL Z=0xFFFFFFFF_FFFFFFF2. Zhighout then Zlowout show each half.
- DIV/shift: Y=−7, bus=2 → DIV low=0xFFFFFFFD, high=0xFFFFFFFF. SHRA Y=0x80000000 by 4 → 0xF8000000. ROL 0x80000001 by 1 → 0x00000003.
